ibus_dbus_arbiter: RTL and testbench
====================================

// Module: ibus_dbus_arbiter
// PURPOSE
//  Shares one memory port between the fetch path (ireq/iresp) and the memory
//  stage (dreq/dresp) of the pipeline core, so the core fits a single-port RAM/bus.
//  The block is a registered-grant FSM: data bus has priority, a streak counter
//  bounds instruction-fetch starvation, and the winning request is latched until
//  the single-beat downstream transaction completes. It sits between core and memory.
// PARAMETERS
//  MAX_D_STREAK  4  consecutive dbus grants allowed while ireq_valid is pending (1..15)
// PORTS
//  clk           in   1   clock, all state on rising edge
//  reset         in   1   asynchronous, active-low reset (0 = reset)
//  ireq_valid    in   1   fetch request; held until iresp_data_ok
//  ireq_addr     in   64  fetch address
//  iresp_addr_ok out  1   fetch request accepted (pulses with data_ok)
//  iresp_data_ok out  1   fetch data valid, one-cycle pulse
//  iresp_data    out  32  fetch data (oresp_data[31:0] or [63:32] by ireq addr[2])
//  dreq_valid    in   1   data request; held until dresp_data_ok
//  dreq_addr     in   64  data address
//  dreq_size     in   3   log2 access bytes (0..3)
//  dreq_strobe   in   8   byte write enables; 0 = read
//  dreq_data     in   64  write data
//  dresp_addr_ok out  1   data request accepted (pulses with data_ok)
//  dresp_data_ok out  1   data response valid, one-cycle pulse
//  dresp_data    out  64  read data
//  oreq_valid    out  1   downstream request
//  oreq_is_write out  1   |strobe of latched dbus request; 0 for fetch
//  oreq_addr     out  64  latched address
//  oreq_size     out  3   latched size; 3'd2 for fetch
//  oreq_strobe   out  8   latched strobe; 0 for fetch
//  oreq_data     out  64  latched write data; 0 for fetch
//  oresp_ready   in   1   downstream completes the transaction this cycle
//  oresp_data    in   64  downstream read data, valid with oresp_ready
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, streak=0, all latches 0; every output 0.
//    Reset mid-transaction abandons it; no data_ok is ever issued for it.
//  - States: IDLE, BUSY_I, BUSY_D.
//    IDLE: dreq_valid & (streak<MAX_D_STREAK | ~ireq_valid) -> BUSY_D, latch dreq_*.
//          else ireq_valid -> BUSY_I, latch ireq_addr. else stay.
//          oreq_valid=0 in IDLE (grant is registered; no combinational path req->oreq).
//    BUSY_x: oreq_valid=1 from latches; on oresp_ready: owner addr_ok=data_ok=1
//          same cycle, resp data passed combinationally from oresp_data; next IDLE.
//  - Latency: request seen in IDLE at cycle t -> oreq_valid at t+1 -> data_ok in the
//    oresp_ready cycle (earliest t+1). Back-to-back requests have >=1 IDLE cycle between.
//  - Streak: on BUSY_D completion, streak = ireq_valid ? sat(streak+1) : 0.
//    On BUSY_I completion streak=0. Saturates at MAX_D_STREAK, never wraps.
//  - Simultaneous ireq/dreq in IDLE with streak<MAX: dbus wins. At streak==MAX: ibus wins.
//  - Requester inputs are ignored while BUSY_x; changes to held fields do not affect oreq_*.
//  - Non-owner addr_ok/data_ok are 0 always; resp data outputs are 0 when data_ok=0.
//  - oresp_ready in IDLE is ignored (no pulse generated).
// TESTING
//  - Reset: hold reset=0 with both valids=1 -> all outputs 0; release -> oreq_valid at 2nd edge.
//  - Lone fetch 0x8000_0004, ready after 3 cycles, oresp_data=0xAABBCCDD_11223344 ->
//    iresp_data=0xAABBCCDD, one-cycle data_ok, dresp_* stay 0.
//  - Simultaneous ireq+dreq (store, strobe 0x0F, addr 0x8001_0000) -> dbus granted first,
//    oreq_is_write=1, oreq_strobe=0x0F; fetch granted after one IDLE cycle.
//  - Continuous dreq + ireq, MAX_D_STREAK=4, ready every grant -> grant order D,D,D,D,I,D...
//  - Requester changes dreq_addr while BUSY_D -> oreq_addr unchanged until completion.
//  - Assert reset=0 while BUSY_I with ready pending -> no iresp_data_ok; state IDLE after release.

Source files
------------

// File: rtl/ibus_dbus_arbiter_if.sv
// Bus bundle between the core's fetch/memory-stage ports, the arbiter and the
// single downstream memory port.
//   ireq_* / iresp_* : instruction-fetch request and response
//   dreq_* / dresp_* : data (load/store) request and response
//   oreq_* / oresp_* : shared downstream single-beat transaction
// Modports:
//   slave  : the arbiter's view (takes core requests, drives the downstream request)
//   master : the environment's view (core plus memory)
interface ibus_dbus_arbiter_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  logic        oreq_valid;
  logic        oreq_is_write;
  logic [63:0] oreq_addr;
  logic [2:0]  oreq_size;
  logic [7:0]  oreq_strobe;
  logic [63:0] oreq_data;
  logic        oresp_ready;
  logic [63:0] oresp_data;

  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_addr_ok, iresp_data_ok, iresp_data,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    output oreq_valid, oreq_is_write, oreq_addr, oreq_size, oreq_strobe, oreq_data,
    input  oresp_ready, oresp_data
  );

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_addr_ok, iresp_data_ok, iresp_data,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    input  oreq_valid, oreq_is_write, oreq_addr, oreq_size, oreq_strobe, oreq_data,
    output oresp_ready, oresp_data
  );
endinterface

// File: rtl/ibus_dbus_arbiter.sv
// Shares one single-port memory between the fetch path and the memory stage.
// Registered-grant FSM: the data bus has priority, a streak counter bounds how
// long a pending fetch can be starved, and the winning request is latched until
// its single-beat downstream transaction completes.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous active-low reset
//   bus   : ibus_dbus_arbiter_if.slave (fetch, data and downstream signals)
module ibus_dbus_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4  // 1..15
) (
  input logic               clk,
  input logic               reset,
  ibus_dbus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusyI = 2'd1,
    StBusyD = 2'd2
  } state_e;

  localparam logic [3:0] MaxStreak = 4'(MAX_D_STREAK);

  state_e      r_state, w_state_d;
  logic [3:0]  r_streak, w_streak_d;
  logic [63:0] r_addr;
  logic [2:0]  r_size;
  logic [7:0]  r_strobe;
  logic [63:0] r_data;
  logic        w_load_i, w_load_d;

  always_comb begin
    w_state_d  = r_state;
    w_streak_d = r_streak;
    w_load_i   = 1'b0;
    w_load_d   = 1'b0;

    bus.iresp_addr_ok = 1'b0;
    bus.iresp_data_ok = 1'b0;
    bus.iresp_data    = 32'd0;
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    bus.dresp_data    = 64'd0;
    bus.oreq_valid    = 1'b0;
    bus.oreq_is_write = 1'b0;
    bus.oreq_addr     = 64'd0;
    bus.oreq_size     = 3'd0;
    bus.oreq_strobe   = 8'd0;
    bus.oreq_data     = 64'd0;

    // Downstream request comes only from the latches, never from requester inputs.
    if (r_state != StIdle) begin
      bus.oreq_valid    = 1'b1;
      bus.oreq_is_write = |r_strobe;
      bus.oreq_addr     = r_addr;
      bus.oreq_size     = r_size;
      bus.oreq_strobe   = r_strobe;
      bus.oreq_data     = r_data;
    end

    unique case (r_state)
      StIdle: begin
        // Fetch wins only once the data bus has used up its streak allowance.
        if (bus.dreq_valid && ((r_streak < MaxStreak) || !bus.ireq_valid)) begin
          w_load_d  = 1'b1;
          w_state_d = StBusyD;
        end else if (bus.ireq_valid) begin
          w_load_i  = 1'b1;
          w_state_d = StBusyI;
        end
      end
      StBusyI: begin
        if (bus.oresp_ready) begin
          bus.iresp_addr_ok = 1'b1;
          bus.iresp_data_ok = 1'b1;
          bus.iresp_data    = r_addr[2] ? bus.oresp_data[63:32] : bus.oresp_data[31:0];
          w_streak_d        = 4'd0;
          w_state_d         = StIdle;
        end
      end
      StBusyD: begin
        if (bus.oresp_ready) begin
          bus.dresp_addr_ok = 1'b1;
          bus.dresp_data_ok = 1'b1;
          bus.dresp_data    = bus.oresp_data;
          // Count only grants that actually delayed a waiting fetch; saturate.
          if (!bus.ireq_valid) begin
            w_streak_d = 4'd0;
          end else if (r_streak < MaxStreak) begin
            w_streak_d = r_streak + 4'd1;
          end
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_streak <= 4'd0;
      r_addr   <= 64'd0;
      r_size   <= 3'd0;
      r_strobe <= 8'd0;
      r_data   <= 64'd0;
    end else begin
      r_state  <= w_state_d;
      r_streak <= w_streak_d;
      if (w_load_d) begin
        r_addr   <= bus.dreq_addr;
        r_size   <= bus.dreq_size;
        r_strobe <= bus.dreq_strobe;
        r_data   <= bus.dreq_data;
      end else if (w_load_i) begin
        r_addr   <= bus.ireq_addr;
        r_size   <= 3'd2;
        r_strobe <= 8'd0;
        r_data   <= 64'd0;
      end
    end
  end

endmodule

// File: tb/tb_ibus_dbus_arbiter.sv
// Self-checking bench for ibus_dbus_arbiter: requester agents feed a scoreboard
// of expected responses; a memory model answers the downstream port.
module tb_ibus_dbus_arbiter;
  localparam int unsigned MaxDStreak = 4;

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
    int          start;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ibus_dbus_arbiter_if bus();

  ibus_dbus_arbiter #(.MAX_D_STREAK(MaxDStreak)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  req_t        i_src[$], d_src[$], iq[$], dq[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          mem_delay = 0;
  int          mem_cnt = 0;
  bit          mem_always = 1'b0;
  bit          mem_fixed = 1'b0;
  logic [63:0] mem_fixed_data = 64'd0;
  bit          lat_chk = 1'b0;
  bit          scramble = 1'b0;
  int          d_cur_start = 0;
  int          i_last_lat = 0;
  logic [63:0] order_bits = 64'd0;
  int          order_n = 0;

  // Memory contents as a function of address.
  function automatic logic [63:0] mem_word(logic [63:0] a);
    if (mem_fixed) return mem_fixed_data;
    return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0] + 32'd7};
  endfunction

  task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push_i(logic [63:0] addr);
    req_t r;
    r = '{addr: addr, size: 3'd2, strobe: 8'd0, data: 64'd0, start: 0};
    i_src.push_back(r);
  endtask

  task automatic push_d(logic [63:0] addr, logic [2:0] size, logic [7:0] strobe,
                        logic [63:0] data);
    req_t r;
    r = '{addr: addr, size: size, strobe: strobe, data: data, start: 0};
    d_src.push_back(r);
  endtask

  // One clock of requesters + memory + scoreboard, starting at a falling edge.
  task automatic agent_cycle();
    req_t        e;
    logic [63:0] w;
    bit          i_done, d_done;
    @(negedge clk);
    if (mem_always || (bus.oreq_valid && mem_cnt >= mem_delay)) begin
      bus.oresp_ready = 1'b1;
      bus.oresp_data  = mem_word(bus.oreq_addr);
      mem_cnt         = 0;
    end else begin
      bus.oresp_ready = 1'b0;
      bus.oresp_data  = {$urandom, $urandom};
      mem_cnt         = bus.oreq_valid ? mem_cnt + 1 : 0;
    end
    if (!bus.ireq_valid && i_src.size() > 0) begin
      e             = i_src.pop_front();
      e.start       = cyc;
      bus.ireq_valid = 1'b1;
      bus.ireq_addr  = e.addr;
      iq.push_back(e);
    end
    if (!bus.dreq_valid && d_src.size() > 0) begin
      e               = d_src.pop_front();
      e.start         = cyc;
      d_cur_start     = cyc;
      bus.dreq_valid  = 1'b1;
      bus.dreq_addr   = e.addr;
      bus.dreq_size   = e.size;
      bus.dreq_strobe = e.strobe;
      bus.dreq_data   = e.data;
      dq.push_back(e);
    end
    #2;
    i_done = bus.iresp_data_ok;
    d_done = bus.dresp_data_ok;
    if (i_done) begin
      if (iq.size() == 0) begin
        check_eq("i_spurious", 64'd1, 64'd0);
      end else begin
        e = iq.pop_front();
        w = mem_word(e.addr);
        check_eq("i_data", 64'(bus.iresp_data), e.addr[2] ? 64'(w[63:32]) : 64'(w[31:0]));
        check_eq("i_addr_ok", 64'(bus.iresp_addr_ok), 64'd1);
        check_eq("i_oreq_addr", bus.oreq_addr, e.addr);
        check_eq("i_oreq_attr", 64'({bus.oreq_is_write, bus.oreq_size, bus.oreq_strobe}),
                 64'({1'b0, 3'd2, 8'h00}));
        check_eq("i_oreq_data", bus.oreq_data, 64'd0);
        check_eq("i_excl", 64'(bus.dresp_data_ok | bus.dresp_addr_ok), 64'd0);
        i_last_lat = cyc - e.start;
        if (lat_chk) check_eq("i_latency", 64'(i_last_lat), 64'(mem_delay + 1));
        order_bits = {order_bits[62:0], 1'b1};
        order_n++;
      end
    end else begin
      check_eq("i_quiet", 64'({bus.iresp_addr_ok, bus.iresp_data}), 64'd0);
    end
    if (d_done) begin
      if (dq.size() == 0) begin
        check_eq("d_spurious", 64'd1, 64'd0);
      end else begin
        e = dq.pop_front();
        check_eq("d_data", bus.dresp_data, mem_word(e.addr));
        check_eq("d_addr_ok", 64'(bus.dresp_addr_ok), 64'd1);
        check_eq("d_oreq_addr", bus.oreq_addr, e.addr);
        check_eq("d_oreq_attr", 64'({bus.oreq_is_write, bus.oreq_size, bus.oreq_strobe}),
                 64'({|e.strobe, e.size, e.strobe}));
        check_eq("d_oreq_data", bus.oreq_data, e.data);
        check_eq("d_excl", 64'(bus.iresp_data_ok | bus.iresp_addr_ok), 64'd0);
        order_bits = {order_bits[62:0], 1'b0};
        order_n++;
      end
    end else begin
      check_eq("d_quiet", 64'({bus.dresp_addr_ok, |bus.dresp_data}), 64'd0);
    end
    #1;
    if (i_done) bus.ireq_valid = 1'b0;
    if (d_done) bus.dreq_valid = 1'b0;
    // Held fields may change once the grant is latched; the DUT must ignore them.
    if (scramble && bus.dreq_valid && (cyc - d_cur_start) >= 1) begin
      bus.dreq_addr   = {$urandom, $urandom};
      bus.dreq_size   = 3'($urandom);
      bus.dreq_strobe = 8'($urandom);
      bus.dreq_data   = {$urandom, $urandom};
    end
  endtask

  task automatic run_until_idle(string tag, int budget);
    int n = 0;
    while ((i_src.size() + d_src.size() + iq.size() + dq.size()) != 0 && n < budget) begin
      agent_cycle();
      n++;
    end
    check_eq(tag, 64'(i_src.size() + d_src.size() + iq.size() + dq.size()), 64'd0);
    repeat (2) agent_cycle();
  endtask

  initial begin
    req_t r;
    reset           = 1'b0;
    bus.ireq_valid  = 1'b0;
    bus.ireq_addr   = 64'd0;
    bus.dreq_valid  = 1'b0;
    bus.dreq_addr   = 64'd0;
    bus.dreq_size   = 3'd0;
    bus.dreq_strobe = 8'd0;
    bus.dreq_data   = 64'd0;
    bus.oresp_ready = 1'b0;
    bus.oresp_data  = 64'd0;

    // Reset held with both requesters and the memory active: everything quiet.
    r = '{addr: 64'h1000, size: 3'd3, strobe: 8'd0, data: 64'd0, start: 0};
    dq.push_back(r);
    bus.dreq_valid = 1'b1;
    bus.dreq_addr  = r.addr;
    bus.dreq_size  = r.size;
    r = '{addr: 64'h2000, size: 3'd2, strobe: 8'd0, data: 64'd0, start: 0};
    iq.push_back(r);
    bus.ireq_valid  = 1'b1;
    bus.ireq_addr   = r.addr;
    bus.oresp_ready = 1'b1;
    bus.oresp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      #1;
      check_eq("rst_oreq", 64'({bus.oreq_valid, bus.oreq_is_write, |bus.oreq_addr,
               |bus.oreq_size, |bus.oreq_strobe, |bus.oreq_data}), 64'd0);
      check_eq("rst_resp", 64'({bus.iresp_addr_ok, bus.iresp_data_ok, |bus.iresp_data,
               bus.dresp_addr_ok, bus.dresp_data_ok, |bus.dresp_data}), 64'd0);
    end
    @(negedge clk);
    bus.oresp_ready = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("rel_idle", 64'(bus.oreq_valid), 64'd0);
    @(negedge clk);
    #1;
    check_eq("rel_grant", 64'(bus.oreq_valid), 64'd1);
    check_eq("rel_dbus_first", bus.oreq_addr, 64'h1000);
    run_until_idle("rel_drain", 50);

    // Lone fetch, memory answers after three waiting cycles.
    mem_delay      = 3;
    mem_fixed      = 1'b1;
    mem_fixed_data = 64'hAABBCCDD_11223344;
    lat_chk        = 1'b1;
    push_i(64'h8000_0004);
    run_until_idle("lone_drain", 50);
    mem_fixed = 1'b0;
    lat_chk   = 1'b0;

    // Simultaneous store and fetch: store first, fetch after one idle cycle.
    mem_delay  = 0;
    order_bits = 64'd0;
    order_n    = 0;
    push_d(64'h8001_0000, 3'd2, 8'h0F, 64'h0123_4567_89AB_CDEF);
    push_i(64'h8000_0100);
    run_until_idle("sim_drain", 50);
    check_eq("sim_count", 64'(order_n), 64'd2);
    check_eq("sim_order", order_bits, 64'b01);
    check_eq("sim_i_lat", 64'(i_last_lat), 64'd3);

    // Continuous traffic on both sides: streak allowance then one fetch.
    order_bits = 64'd0;
    order_n    = 0;
    for (int k = 0; k < 8; k++) push_d(64'h9000_0000 + 64'(k * 8), 3'd3, 8'd0, 64'd0);
    push_i(64'h8000_0200);
    push_i(64'h8000_0204);
    run_until_idle("streak_drain", 200);
    check_eq("streak_count", 64'(order_n), 64'd10);
    check_eq("streak_order", order_bits, 64'b0000100001);

    // Requester scribbles over its held fields while the grant is in flight.
    mem_delay = 4;
    scramble  = 1'b1;
    push_d(64'hA000_0010, 3'd3, 8'hFF, 64'h1111_2222_3333_4444);
    push_d(64'hA000_0020, 3'd1, 8'h00, 64'd0);
    push_d(64'hA000_0038, 3'd0, 8'h80, 64'h5500_0000_0000_0000);
    run_until_idle("scr_drain", 100);
    scramble = 1'b0;

    // Random mix, half of it with the memory claiming ready every cycle.
    for (int ph = 0; ph < 2; ph++) begin
      mem_always = (ph == 1);
      mem_delay  = int'($urandom_range(0, 3));
      for (int k = 0; k < 20; k++) begin
        if ($urandom_range(0, 1) == 0) push_i({$urandom, $urandom});
        else push_d({$urandom, $urandom}, 3'($urandom_range(0, 3)), 8'($urandom),
                    {$urandom, $urandom});
      end
      run_until_idle("rand_drain", 600);
    end
    mem_always = 1'b0;

    // Reset while a fetch is waiting on the memory: the fetch is abandoned.
    mem_delay = 10;
    push_i(64'h8000_0010);
    repeat (4) agent_cycle();
    @(negedge clk);
    bus.oresp_ready = 1'b1;
    bus.oresp_data  = 64'h0BAD_0BAD_0BAD_0BAD;
    #1;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_no_ok", 64'({bus.iresp_data_ok, bus.iresp_addr_ok}), 64'd0);
    check_eq("mid_rst_oreq", 64'(bus.oreq_valid), 64'd0);
    iq.delete();
    bus.ireq_valid  = 1'b0;
    bus.oresp_ready = 1'b0;
    mem_cnt         = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) agent_cycle();
    check_eq("mid_rst_idle", 64'(bus.oreq_valid), 64'd0);
    mem_delay = 0;
    push_i(64'h8000_0014);
    run_until_idle("post_rst_drain", 50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
